// File: rtl/uart_baud_pkg.sv
// Shared constants for the UART baud-tick generator: the selectable baud table
// and the elaboration-time phase-increment calculation.
package uart_baud_pkg;

  localparam int SEL_W          = 3;
  localparam int OVERSAMPLE_DEF = 16;

  localparam logic [31:0] BAUD [8] = '{
    32'd9600,   32'd19200,  32'd38400,  32'd57600,
    32'd115200, 32'd230400, 32'd460800, 32'd921600
  };

  // round(baud * oversample * 2^acc_w / clk_hz); only ever called on constants
  function automatic logic [63:0] inc_calc(input logic [31:0]   baud,
                                           input int unsigned   oversample,
                                           input int unsigned   acc_w,
                                           input logic [63:0]   clk_hz);
    logic [127:0] num;
    num = (128'(baud) * 128'(oversample)) << acc_w;
    return 64'((num + 128'(clk_hz >> 1)) / 128'(clk_hz));
  endfunction

endpackage

// File: rtl/uart_nco.sv
// Fractional phase accumulator: carry pulses at inc/2^ACC_W of the clock rate.
// The increment is reloaded synchronously; a low enable clears the phase.
module uart_nco #(
  parameter int unsigned       ACC_W   = 32,
  parameter logic [ACC_W-1:0]  INC_RST = '0
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [ACC_W-1:0] inc_new,
  output logic             carry
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W:0]   sum;

  assign sum   = {1'b0, acc} + {1'b0, inc};
  assign carry = en & sum[ACC_W];

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      inc <= INC_RST;
    end else begin
      acc <= en ? sum[ACC_W-1:0] : '0;
      if (load)
        inc <= inc_new;
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud-tick generator: oversample tick, bit tick and re-alignable mid-bit
// strobe, all used as clock enables; baud selectable at run time by handshake.
module uart_baud_gen
  import uart_baud_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned DEFAULT_SEL = 0
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [SEL_W-1:0] cfg_sel,
  output logic             cfg_ready,
  input  logic             rx_align,
  output logic             rx_tick,
  output logic             tx_tick,
  output logic             rx_sample,
  output logic             rx_active
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] MID_M1 = CNT_W'(OVERSAMPLE / 2 - 1);

  localparam logic [ACC_W-1:0] INC_TBL [8] = '{
    ACC_W'(inc_calc(BAUD[0], OVERSAMPLE, ACC_W, 64'(CLK_HZ))),
    ACC_W'(inc_calc(BAUD[1], OVERSAMPLE, ACC_W, 64'(CLK_HZ))),
    ACC_W'(inc_calc(BAUD[2], OVERSAMPLE, ACC_W, 64'(CLK_HZ))),
    ACC_W'(inc_calc(BAUD[3], OVERSAMPLE, ACC_W, 64'(CLK_HZ))),
    ACC_W'(inc_calc(BAUD[4], OVERSAMPLE, ACC_W, 64'(CLK_HZ))),
    ACC_W'(inc_calc(BAUD[5], OVERSAMPLE, ACC_W, 64'(CLK_HZ))),
    ACC_W'(inc_calc(BAUD[6], OVERSAMPLE, ACC_W, 64'(CLK_HZ))),
    ACC_W'(inc_calc(BAUD[7], OVERSAMPLE, ACC_W, 64'(CLK_HZ)))
  };

  if ((64'(BAUD[7]) * 64'(OVERSAMPLE) >= 64'(CLK_HZ)) ||
      (OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_cfg
    $error("uart_baud_gen: OVERSAMPLE must be even and >= 4, and top baud x OVERSAMPLE below CLK_HZ");
  end

  logic             carry;
  logic             tx_wrap;
  logic             load;
  logic             pending;
  logic [SEL_W-1:0] sel_q;
  logic [CNT_W-1:0] tx_cnt;
  logic [CNT_W-1:0] rx_phase;

  assign tx_wrap = carry && (tx_cnt == LAST);
  // A pending baud change lands on a bit boundary so no bit is ever split
  assign load    = pending && (!en || tx_wrap);

  uart_nco #(
    .ACC_W   (ACC_W),
    .INC_RST (INC_TBL[SEL_W'(DEFAULT_SEL)])
  ) u_nco (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .en      (en),
    .load    (load),
    .inc_new (INC_TBL[sel_q]),
    .carry   (carry)
  );

  // An align on a carry cycle wins, so that tick does not count toward rx_phase
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt    <= '0;
      rx_phase  <= '0;
      rx_active <= 1'b0;
      rx_tick   <= 1'b0;
      tx_tick   <= 1'b0;
      rx_sample <= 1'b0;
    end else if (!en) begin
      tx_cnt    <= '0;
      rx_phase  <= '0;
      rx_active <= 1'b0;
      rx_tick   <= 1'b0;
      tx_tick   <= 1'b0;
      rx_sample <= 1'b0;
    end else begin
      rx_tick <= carry;
      tx_tick <= tx_wrap;
      if (carry)
        tx_cnt <= tx_wrap ? '0 : tx_cnt + 1'b1;
      if (rx_align) begin
        rx_phase  <= '0;
        rx_active <= 1'b1;
        rx_sample <= 1'b0;
      end else if (carry && rx_active) begin
        rx_phase  <= (rx_phase == LAST) ? '0 : rx_phase + 1'b1;
        rx_sample <= (rx_phase == MID_M1);
      end else begin
        rx_sample <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      cfg_ready <= 1'b1;
      sel_q     <= SEL_W'(DEFAULT_SEL);
    end else if (load) begin
      pending   <= 1'b0;
      cfg_ready <= 1'b1;
    end else if (cfg_valid && cfg_ready) begin
      sel_q     <= cfg_sel;
      pending   <= 1'b1;
      cfg_ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen at 50 MHz, OVERSAMPLE=16, ACC_W=32.
// Expected edge counts are hand-derived from ceil(k * 2^32 / INC).
module tb_uart_baud_gen;

  logic       clk_50m = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [2:0] cfg_sel = 3'd0;
  logic       rx_align = 1'b0;
  logic       cfg_ready, rx_tick, tx_tick, rx_sample, rx_active;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int cyc0 = 0;
  int t_prev = 0;
  int ticks_seen = 0;
  int samples_seen = 0;
  int ready_hi = 0;
  int stray = 0;
  bit found;

  uart_baud_gen #(
    .CLK_HZ      (50_000_000),
    .OVERSAMPLE  (16),
    .ACC_W       (32),
    .DEFAULT_SEL (0)
  ) dut (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_sel   (cfg_sel),
    .cfg_ready (cfg_ready),
    .rx_align  (rx_align),
    .rx_tick   (rx_tick),
    .tx_tick   (tx_tick),
    .rx_sample (rx_sample),
    .rx_active (rx_active)
  );

  always #10 clk_50m = ~clk_50m;

  always @(posedge clk_50m) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkRange(input string tag, input logic [31:0] obs,
                            input logic [31:0] lo, input logic [31:0] hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Drive inputs at a falling edge, then advance one rising edge
  task automatic applyStimulus(input logic en_v, input logic valid_v,
                               input logic [2:0] sel_v, input logic align_v);
    en        = en_v;
    cfg_valid = valid_v;
    cfg_sel   = sel_v;
    rx_align  = align_v;
    @(posedge clk_50m);
    @(negedge clk_50m);
  endtask

  // which: 0 rx_tick, 1 tx_tick, 2 rx_sample; returns at the falling edge it is seen
  task automatic waitFor(input int which, input int budget, input string tag);
    logic s;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk_50m);
      @(negedge clk_50m);
      if (rx_tick === 1'b1) ticks_seen++;
      if (rx_sample === 1'b1) samples_seen++;
      case (which)
        0:       s = rx_tick;
        1:       s = tx_tick;
        default: s = rx_sample;
      endcase
      if (s === 1'b1) found = 1'b1;
      else if (cfg_ready !== 1'b0) ready_hi++;
    end
    checkOutput(tag, {31'd0, found}, 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk_50m);
    checkOutput("rst cfg_ready", cfg_ready, 1);
    checkOutput("rst rx_tick", rx_tick, 0);
    checkOutput("rst tx_tick", tx_tick, 0);
    checkOutput("rst rx_sample", rx_sample, 0);
    checkOutput("rst rx_active", rx_active, 0);

    // 9600 baud from reset
    en = 1'b1;
    rst_n = 1'b1;
    cyc0 = cyc;
    waitFor(0, 400, "first rx_tick seen");
    checkOutput("first rx_tick edge", cyc - cyc0, 326);
    waitFor(0, 400, "second rx_tick seen");
    checkOutput("second rx_tick edge", cyc - cyc0, 652);
    waitFor(1, 6000, "first tx_tick seen");
    checkOutput("first tx_tick edge", cyc - cyc0, 5209);
    checkOutput("rx_tick with tx_tick", rx_tick, 1);

    // Switch to 115200 mid-bit; must wait for the next bit boundary
    repeat (100) @(negedge clk_50m);
    applyStimulus(1'b1, 1'b1, 3'd4, 1'b0);
    cfg_valid = 1'b0;
    checkOutput("cfg_ready after accept", cfg_ready, 0);
    ready_hi = 0;
    waitFor(1, 6000, "tx_tick after request seen");
    checkOutput("tx_tick with old rate", cyc - cyc0, 10417);
    checkOutput("cfg_ready high while pending", ready_hi, 0);
    checkOutput("cfg_ready after load", cfg_ready, 1);
    t_prev = cyc;
    waitFor(1, 600, "tx_tick 115200 seen");
    checkRange("tx spacing 115200", cyc - t_prev, 434, 435);
    t_prev = cyc;
    waitFor(0, 60, "rx_tick 115200 seen");
    checkRange("rx spacing 115200", cyc - t_prev, 27, 28);

    // Alignment: sample on the 8th tick, then every 16th
    applyStimulus(1'b1, 1'b0, 3'd4, 1'b1);
    rx_align = 1'b0;
    checkOutput("rx_active after align", rx_active, 1);
    ticks_seen = 0;
    waitFor(2, 400, "first rx_sample seen");
    checkOutput("ticks to first sample", ticks_seen, 8);
    checkOutput("rx_tick with sample", rx_tick, 1);
    ticks_seen = 0;
    waitFor(2, 600, "second rx_sample seen");
    checkOutput("ticks between samples", ticks_seen, 16);

    // Re-align after 3 ticks restarts the count
    applyStimulus(1'b1, 1'b0, 3'd4, 1'b1);
    rx_align = 1'b0;
    samples_seen = 0;
    for (int k = 0; k < 3; k++) waitFor(0, 60, "pre-realign tick seen");
    checkOutput("no sample before realign", samples_seen, 0);
    applyStimulus(1'b1, 1'b0, 3'd4, 1'b1);
    rx_align = 1'b0;
    ticks_seen = 0;
    waitFor(2, 400, "realigned sample seen");
    checkOutput("ticks after realign", ticks_seen, 8);

    // Align coincident with carry: carry 1 at edge 28, carry 9 at edge 245
    applyStimulus(1'b0, 1'b0, 3'd4, 1'b0);
    checkOutput("en low rx_active", rx_active, 0);
    en = 1'b1;
    rx_align = 1'b1;
    cyc0 = cyc;
    @(negedge clk_50m);
    rx_align = 1'b0;
    repeat (26) @(negedge clk_50m);
    rx_align = 1'b1;
    @(negedge clk_50m);
    checkOutput("carry on align edge", rx_tick, 1);
    rx_align = 1'b0;
    ticks_seen = 0;
    waitFor(2, 400, "sample after coincident align seen");
    checkOutput("coincident sample edge", cyc - cyc0, 245);
    checkOutput("coincident ticks to sample", ticks_seen, 8);

    // Pending request applied while disabled: 230400, first tick at edge 14
    repeat (5) @(negedge clk_50m);
    applyStimulus(1'b1, 1'b1, 3'd5, 1'b0);
    cfg_valid = 1'b0;
    en = 1'b0;
    checkOutput("cfg_ready pending before en low", cfg_ready, 0);
    @(negedge clk_50m);
    checkOutput("cfg_ready after load en low", cfg_ready, 1);
    checkOutput("en low rx_tick", rx_tick, 0);
    checkOutput("en low tx_tick", tx_tick, 0);
    checkOutput("en low rx_active cleared", rx_active, 0);
    stray = 0;
    repeat (20) begin
      @(negedge clk_50m);
      if (rx_tick !== 1'b0 || tx_tick !== 1'b0 || rx_sample !== 1'b0 || rx_active !== 1'b0)
        stray++;
    end
    checkOutput("outputs idle while disabled", stray, 0);
    en = 1'b1;
    cyc0 = cyc;
    waitFor(0, 100, "rx_tick 230400 seen");
    checkOutput("first rx_tick 230400 edge", cyc - cyc0, 14);

    // Reset mid-request discards it and restores the default rate
    applyStimulus(1'b1, 1'b0, 3'd5, 1'b1);
    rx_align = 1'b0;
    checkOutput("rx_active before reset", rx_active, 1);
    applyStimulus(1'b1, 1'b1, 3'd2, 1'b0);
    cfg_valid = 1'b0;
    checkOutput("cfg_ready before reset", cfg_ready, 0);
    #5 rst_n = 1'b0;
    #1;
    checkOutput("async rst cfg_ready", cfg_ready, 1);
    checkOutput("async rst rx_active", rx_active, 0);
    checkOutput("async rst rx_tick", rx_tick, 0);
    checkOutput("async rst tx_tick", tx_tick, 0);
    checkOutput("async rst rx_sample", rx_sample, 0);
    @(negedge clk_50m);
    rst_n = 1'b1;
    cyc0 = cyc;
    waitFor(0, 400, "rx_tick after reset seen");
    checkOutput("default rate after reset", cyc - cyc0, 326);
    checkOutput("cfg_ready after reset", cfg_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
